// File: rtl/debounce_pkg.sv
// Shared definitions for the debounce_sync block.
//   state_e                : qualification FSM states
//   DEFAULT_SYNC_STAGES    : default synchronizer depth
//   DEFAULT_STABLE_CYCLES  : default number of agreeing samples before q moves
package debounce_pkg;

  localparam int unsigned DEFAULT_SYNC_STAGES   = 2;
  localparam int unsigned DEFAULT_STABLE_CYCLES = 4;

  typedef enum logic [1:0] {
    STABLE_LO = 2'd0,
    WAIT_HI   = 2'd1,
    STABLE_HI = 2'd2,
    WAIT_LO   = 2'd3
  } state_e;

  // True for the two qualification states; busy mirrors this.
  function automatic logic is_wait(input state_e s);
    return (s == WAIT_HI) || (s == WAIT_LO);
  endfunction

endpackage

// File: rtl/debounce_sync_chain.sv
// sync_chain: multi-flop synchronizer for a single asynchronous level.
//   clk   : sampling clock
//   rst   : synchronous active-high reset, clears every stage
//   d_in  : asynchronous input level
//   d_out : synchronized level (last stage of the chain)
module sync_chain #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d_in,
  output logic d_out
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk) begin
    if (rst) begin
      chain <= '0;
    end else begin
      chain <= {chain[STAGES-2:0], d_in};
    end
  end

  assign d_out = chain[STAGES-1];

endmodule

// File: rtl/debounce_sync.sv
// debounce_sync: synchronizes a raw asynchronous level and only lets q follow
// it after STABLE_CYCLES consecutive agreeing samples.
//   clk  : single clock, all state on the rising edge
//   rst  : synchronous active-high reset
//   d    : raw asynchronous level
//   q    : debounced, synchronized level (registered)
//   rise : one-cycle pulse after q goes 0->1 (registered)
//   fall : one-cycle pulse after q goes 1->0 (registered)
//   busy : high while a candidate level change is being qualified
module debounce_sync
  import debounce_pkg::*;
#(
  parameter int unsigned SYNC_STAGES   = DEFAULT_SYNC_STAGES,
  parameter int unsigned STABLE_CYCLES = DEFAULT_STABLE_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall,
  output logic busy
);

  if (SYNC_STAGES < 2) begin : g_bad_sync_stages
    $error("debounce_sync: SYNC_STAGES must be at least 2");
  end
  if (STABLE_CYCLES < 1) begin : g_bad_stable_cycles
    $error("debounce_sync: STABLE_CYCLES must be at least 1");
  end

  localparam int unsigned CW = $clog2(STABLE_CYCLES + 1);
  // The qualifying edge is the one where count would reach STABLE_CYCLES,
  // i.e. the edge seen while count already holds STABLE_CYCLES-1.
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam bit            DIRECT   = (STABLE_CYCLES == 1);

  logic          d_s;
  state_e        state;
  logic [CW-1:0] count;

  sync_chain #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk  (clk),
    .rst  (rst),
    .d_in (d),
    .d_out(d_s)
  );

  // busy is registered alongside the state so it is high exactly while the
  // FSM sits in a WAIT state; pulses default low and are set only on a toggle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= STABLE_LO;
      count <= '0;
      q     <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
      busy  <= 1'b0;
    end else begin
      rise <= 1'b0;
      fall <= 1'b0;
      case (state)
        STABLE_LO: begin
          if (d_s) begin
            if (DIRECT) begin
              state <= STABLE_HI;
              q     <= 1'b1;
              rise  <= 1'b1;
              busy  <= 1'b0;
            end else begin
              state <= WAIT_HI;
              count <= CNT_ONE;
              busy  <= 1'b1;
            end
          end
        end

        WAIT_HI: begin
          if (d_s) begin
            if (count == CNT_LAST) begin
              state <= STABLE_HI;
              count <= '0;
              q     <= 1'b1;
              rise  <= 1'b1;
              busy  <= 1'b0;
            end else begin
              count <= count + CNT_ONE;
            end
          end else begin
            state <= STABLE_LO;
            count <= '0;
            busy  <= 1'b0;
          end
        end

        STABLE_HI: begin
          if (!d_s) begin
            if (DIRECT) begin
              state <= STABLE_LO;
              q     <= 1'b0;
              fall  <= 1'b1;
              busy  <= 1'b0;
            end else begin
              state <= WAIT_LO;
              count <= CNT_ONE;
              busy  <= 1'b1;
            end
          end
        end

        WAIT_LO: begin
          if (!d_s) begin
            if (count == CNT_LAST) begin
              state <= STABLE_LO;
              count <= '0;
              q     <= 1'b0;
              fall  <= 1'b1;
              busy  <= 1'b0;
            end else begin
              count <= count + CNT_ONE;
            end
          end else begin
            state <= STABLE_HI;
            count <= '0;
            busy  <= 1'b0;
          end
        end

        default: begin
          state <= STABLE_LO;
          count <= '0;
          q     <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_debounce_sync.sv
module tb_debounce_sync;

  logic clk;
  logic rst;
  logic d;
  logic q0, rise0, fall0, busy0;
  logic q1, rise1, fall1, busy1;

  int unsigned n_chk;
  int unsigned n_fail;

  debounce_sync u_dut0 (
    .clk (clk),
    .rst (rst),
    .d   (d),
    .q   (q0),
    .rise(rise0),
    .fall(fall0),
    .busy(busy0)
  );

  debounce_sync #(
    .SYNC_STAGES  (3),
    .STABLE_CYCLES(1)
  ) u_dut1 (
    .clk (clk),
    .rst (rst),
    .d   (d),
    .q   (q1),
    .rise(rise1),
    .fall(fall1),
    .busy(busy1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference: d_s is d delayed by S edges; q flips once d_s has disagreed
  // with q for C consecutive samples; any agreeing sample resets the run.
  typedef struct {
    logic [7:0] hist;
    int         run;
    logic       q;
    logic       rise;
    logic       fall;
  } mstate_t;

  mstate_t m0, m1;

  function automatic mstate_t model_next(input mstate_t m, input int s, input int c,
                                         input logic r, input logic dv);
    mstate_t n;
    logic    ds;
    n = m;
    if (r) begin
      n.hist = '0;
      n.run  = 0;
      n.q    = 1'b0;
      n.rise = 1'b0;
      n.fall = 1'b0;
      return n;
    end
    ds     = m.hist[s-1];
    n.hist = {m.hist[6:0], dv};
    n.rise = 1'b0;
    n.fall = 1'b0;
    if (ds != m.q) begin
      n.run = m.run + 1;
      if (n.run == c) begin
        n.q    = ds;
        n.rise = ds;
        n.fall = !ds;
        n.run  = 0;
      end
    end else begin
      n.run = 0;
    end
    return n;
  endfunction

  task automatic chk(input string name, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic dv);
    @(negedge clk);
    rst = r;
    d   = dv;
    @(posedge clk);
    m0 = model_next(m0, 2, 4, r, dv);
    m1 = model_next(m1, 3, 1, r, dv);
    #1;
  endtask

  typedef struct {
    logic rst;
    logic d;
    logic q;
    logic rise;
    logic fall;
    logic busy;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic r, input logic dv, input logic eq, input logic er,
                     input logic ef, input logic eb);
    vec_t v;
    v.rst = r; v.d = dv; v.q = eq; v.rise = er; v.fall = ef; v.busy = eb;
    tbl.push_back(v);
  endtask

  initial begin
    int unsigned rises;
    logic        lvl;
    int unsigned runlen;
    n_chk  = 0;
    n_fail = 0;
    rst    = 1'b1;
    d      = 1'b0;
    m0 = model_next('{hist: '0, run: 0, q: 1'b0, rise: 1'b0, fall: 1'b0}, 2, 4, 1'b1, 1'b0);
    m1 = m0;

    // Reset held 3 edges with d=1, then release: q rises at 6th edge.
    for (int i = 0; i < 3; i++) add(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) add(1'b0, 1'b1, i >= 5, i == 5, 1'b0, (i >= 2) && (i <= 4));
    // Drop d with q=1: fall at 6th edge.
    for (int i = 0; i < 8; i++) add(1'b0, 1'b0, i < 5, 1'b0, i == 5, (i >= 2) && (i <= 4));
    // Raise d from a settled low: busy E3..E5, q at E6, single rise.
    for (int i = 0; i < 8; i++) add(1'b0, 1'b1, i >= 5, i == 5, 1'b0, (i >= 2) && (i <= 4));
    for (int i = 0; i < 8; i++) add(1'b0, 1'b0, i < 5, 1'b0, i == 5, (i >= 2) && (i <= 4));

    foreach (tbl[k]) begin
      step(tbl[k].rst, tbl[k].d);
      chk($sformatf("tbl%0d_q", k), q0, tbl[k].q);
      chk($sformatf("tbl%0d_rise", k), rise0, tbl[k].rise);
      chk($sformatf("tbl%0d_fall", k), fall0, tbl[k].fall);
      chk($sformatf("tbl%0d_busy", k), busy0, tbl[k].busy);
    end

    // Three-cycle glitch is rejected.
    for (int i = 0; i < 9; i++) begin
      step(1'b0, i < 3);
      chk("glitch_q", q0, 1'b0);
      chk("glitch_rise", rise0, 1'b0);
      if (i == 4) chk("glitch_busy_mid", busy0, 1'b1);
    end
    chk("glitch_busy_end", busy0, 1'b0);

    // Bounce 1,0,then held 1: q rises 6 edges after the final 0->1.
    rises = 0;
    for (int i = 0; i < 10; i++) begin
      step(1'b0, i != 1);
      if (rise0) rises++;
      chk("bounce_q", q0, i >= 7);
      chk("bounce_rise", rise0, i == 7);
    end
    chk("bounce_single_rise", rises == 1, 1'b1);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0);
    chk("bounce_back_low", q0, 1'b0);

    // Reset at E4 aborts a rising qualification.
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1);
    chk("abort_busy_before", busy0, 1'b1);
    step(1'b1, 1'b1);
    chk("abort_rst_q", q0, 1'b0);
    chk("abort_rst_busy", busy0, 1'b0);
    chk("abort_rst_rise", rise0, 1'b0);
    step(1'b0, 1'b1);
    chk("abort_after_q", q0, 1'b0);
    chk("abort_after_busy", busy0, 1'b0);
    chk("abort_after_rise", rise0, 1'b0);
    step(1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0);

    // Randomized runs against the reference, both parameterizations.
    lvl    = 1'b0;
    runlen = 0;
    for (int i = 0; i < 3000; i++) begin
      logic r;
      if (runlen == 0) begin
        lvl    = ~lvl;
        runlen = $urandom_range(1, 7);
      end
      runlen--;
      r = ($urandom_range(0, 149) == 0);
      step(r, lvl);
      chk("rnd0_q", q0, m0.q);
      chk("rnd0_rise", rise0, m0.rise);
      chk("rnd0_fall", fall0, m0.fall);
      chk("rnd0_busy", busy0, m0.run != 0);
      chk("rnd1_q", q1, m1.q);
      chk("rnd1_rise", rise1, m1.rise);
      chk("rnd1_fall", fall1, m1.fall);
      chk("rnd1_busy", busy1, m1.run != 0);
      chk("rnd_excl", (rise0 && fall0) || (rise1 && fall1), 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/debounce_sync.md
DEBOUNCE_SYNC -- requirements
Module: debounce_sync

Interface
REQ-001 The block SHALL have parameter SYNC_STAGES, default 2, meaning the number of synchronizer flops on d; legal range is 2 or more.
REQ-002 The block SHALL have parameter STABLE_CYCLES, default 4, meaning the consecutive sampled cycles of a new level required before q changes; legal range is 1 or more.
REQ-003 Port clk SHALL be an input, 1 bit wide: the single clock; all state updates on its rising edge.
REQ-004 Port rst SHALL be an input, 1 bit wide: the reset, which is synchronous and active-high.
REQ-005 Port d SHALL be an input, 1 bit wide: the raw asynchronous level (switch, button or external pin).
REQ-006 Port q SHALL be an output, 1 bit wide: the debounced, synchronized level; it directly feeds the downstream D flip-flop stage.
REQ-007 Port rise SHALL be an output, 1 bit wide: a one-cycle pulse when q goes 0->1.
REQ-008 Port fall SHALL be an output, 1 bit wide: a one-cycle pulse when q goes 1->0.
REQ-009 Port busy SHALL be an output, 1 bit wide: high while a candidate level change is being qualified.

Function
REQ-010 d SHALL pass through a SYNC_STAGES-deep flop chain; the last stage (d_s) SHALL be the only signal the control logic reads.
REQ-011 The FSM SHALL have the states STABLE_LO, WAIT_HI, STABLE_HI and WAIT_LO.
REQ-012 STABLE_LO with d_s=1 SHALL go to WAIT_HI with count=1; STABLE_HI with d_s=0 SHALL go to WAIT_LO with count=1.
REQ-013 In WAIT_x with d_s equal to the target level, count SHALL increment; on the edge where count would reach STABLE_CYCLES, the FSM SHALL enter STABLE_x and toggle q.
REQ-014 In WAIT_x with d_s not equal to the target level, the FSM SHALL return to the prior STABLE state, clear count, and leave q, rise and fall unchanged (glitch rejected).
REQ-015 If STABLE_CYCLES=1, the transition SHALL occur directly from STABLE_x on the first differing d_s sample.
REQ-016 Latency: with d changed before capturing edge E1 and held, q SHALL change at edge E(SYNC_STAGES+STABLE_CYCLES); with the defaults this is the 6th edge.
REQ-017 rise and fall SHALL be registered and asserted for exactly the one cycle following the edge on which q toggles; they SHALL never both be high.
REQ-018 busy SHALL be high exactly while the state is WAIT_HI or WAIT_LO.
REQ-019 The counter width SHALL be $clog2(STABLE_CYCLES+1) and the counter SHALL never wrap; it saturates by construction because the state exits at STABLE_CYCLES.
REQ-020 Once in STABLE_x, a continuously held d SHALL produce no further pulses.

Reset
REQ-021 While rst=1 at a clk edge, the synchronizer chain, count, q, rise, fall and busy SHALL all be 0, and the state SHALL be STABLE_LO.
REQ-022 Reset asserted mid-qualification SHALL abort it with no pulse.
REQ-023 If d is held high through reset, q SHALL rise SYNC_STAGES+STABLE_CYCLES edges after the first edge with rst=0.
REQ-024 Reset SHALL take priority over every other event on the same edge.

Structure
REQ-025 Package debounce_pkg SHALL hold the FSM state enum and the default parameter constants.
REQ-026 The synchronizer SHALL be a separate sub-module sync_chain with parameter STAGES and ports clk, rst, d_in and d_out.
REQ-027 The block SHALL contain no combinational path from d to any output.
REQ-028 Elaboration SHALL fail if SYNC_STAGES<2 or STABLE_CYCLES<1.

Verification (defaults, 10-unit clock)
REQ-029 Hold rst=1 for 3 edges with d=1, then release -> q=0 during reset; q=1 and rise=1 for one cycle after the 6th post-release edge.
REQ-030 Raise d before edge E1 and hold it -> busy=1 from E3 to E5; q=1 at E6; rise high for one cycle only; fall stays 0.
REQ-031 Pulse d high for 3 cycles, then low -> q stays 0, rise stays 0, busy returns to 0.
REQ-032 Give d a bounce pattern of 1,0,1,1,1,1 cycles after q=0 -> q rises exactly 6 edges after the final 0->1 transition, with a single rise pulse.
REQ-033 Assert rst at E4 during a rising qualification -> the edge after reset shows q=0, busy=0 and no rise pulse.
REQ-034 With q=1, drop d and hold it low -> q=0 at the 6th edge; fall is high for one cycle; rise stays 0.
